// File: rtl/immediate_extender_pipe.sv
// RISC-V immediate extender: decodes I/S/B/U/J (and CSR zimm when IMM_ZICSR_EN
// is defined) into an N-bit immediate, buffered through a 2-entry skid FIFO.
module immediate_extender_pipe #(
  parameter int unsigned N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         instruction_valid,
  output logic         instruction_ready,
  input  logic [31:0]  instruction,
  output logic         immediate_valid,
  input  logic         immediate_ready,
  output logic [N-1:0] immediate,
  output logic [2:0]   imm_format,
  output logic         imm_illegal
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_RSVD = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam bit NARROW = (N == 32);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm32;
  imm_fmt_e           dec_fmt;
  logic               dec_ill;
  logic [N-1:0]       dec_imm;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};

  // All formats are built as a signed 32-bit value and sign-extended once to N.
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        dec_fmt = FMT_I;
        imm32   = imm_i;
      end
      OPC_OP_IMM: begin
        dec_fmt = FMT_I;
        imm32   = imm_i;
        dec_ill = NARROW && (funct3 == 3'b001 || funct3 == 3'b101) && instruction[25];
      end
      OPC_OP_IMM32: begin
        dec_fmt = FMT_I;
        imm32   = imm_i;
        dec_ill = NARROW;
      end
      OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        if (funct3[2]) begin
          dec_fmt = FMT_Z;
          imm32   = {27'b0, instruction[19:15]};
        end else begin
          dec_fmt = FMT_I;
          imm32   = imm_i;
        end
`else
        dec_fmt = FMT_I;
        imm32   = imm_i;
`endif
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      default: begin
        dec_fmt = FMT_NONE;
        dec_ill = 1'b1;
      end
    endcase
    dec_imm = N'(imm32);
  end

  logic [N-1:0] imm_q [2];
  imm_fmt_e     fmt_q [2];
  logic         ill_q [2];
  logic [1:0]   count_q, count_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic         push, pop;

  assign instruction_ready = (count_q < 2'd2);
  assign immediate_valid   = (count_q != 2'd0);
  assign push = instruction_valid & instruction_ready;
  assign pop  = immediate_valid & immediate_ready;

  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (flush) begin
      count_d = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      if (push) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push && !flush) begin
        imm_q[wr_q] <= dec_imm;
        fmt_q[wr_q] <= dec_fmt;
        ill_q[wr_q] <= dec_ill;
      end
    end
  end

  assign immediate   = imm_q[rd_q];
  assign imm_format  = fmt_q[rd_q];
  assign imm_illegal = ill_q[rd_q];

endmodule
